// File: rtl/device_monitor_multi.sv
// Multi-channel up/down device counter with per-channel alarm, sticky over/underflow
// flags and a one-cycle-delayed registered total of all channel counts.

module device_monitor_multi_lane #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic             on_off,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf
);
    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (change) begin
            if (on_off) begin
                if (count == MAX) begin
                    ovf <= 1'b1;
                    if (SATURATE == 0) count <= '0;
                end else begin
                    count <= count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    unf <= 1'b1;
                    if (SATURATE == 0) count <= MAX;
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end
endmodule

module device_monitor_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 1,
    parameter int THRESH   = 200,
    localparam int TW      = WIDTH + $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       change,
    input  logic [CHANNELS-1:0]       on_off,
    input  logic                      clear,
    output logic [CHANNELS*WIDTH-1:0] counter_out,
    output logic [TW-1:0]             total_out,
    output logic [CHANNELS-1:0]       alarm,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS-1:0]       unf
);
    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

    logic [CHANNELS-1:0][WIDTH-1:0] cnt;
    logic [TW-1:0]                  sum;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        device_monitor_multi_lane #(
            .WIDTH   (WIDTH),
            .SATURATE(SATURATE)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .change(change[i]),
            .on_off(on_off[i]),
            .clear (clear),
            .count (cnt[i]),
            .ovf   (ovf[i]),
            .unf   (unf[i])
        );
        assign alarm[i] = (cnt[i] >= THR);
    end

    assign counter_out = cnt;

    // TW bits hold CHANNELS * (2^WIDTH - 1) without overflow
    always_comb begin
        sum = '0;
        for (int i = 0; i < CHANNELS; i++) sum = sum + TW'(cnt[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       total_out <= '0;
        else if (clear) total_out <= '0;
        else            total_out <= sum;
    end
endmodule

// File: tb/tb_device_monitor_multi.sv
// Directed bench: a saturating instance for the main checks, a wrap-around instance for rollover.

module tb_device_monitor_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  change = '0, on_off = '0;
    logic        clear = 1'b0;
    logic [31:0] counter_out;
    logic [9:0]  total_out;
    logic [3:0]  alarm, ovf, unf;

    logic [3:0]  change2 = '0, on_off2 = '0;
    logic        clear2 = 1'b0;
    logic [31:0] counter_out2;
    logic [9:0]  total_out2;
    logic [3:0]  alarm2, ovf2, unf2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    device_monitor_multi #(.WIDTH(8), .CHANNELS(4), .SATURATE(1), .THRESH(200)) dut (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off), .clear(clear),
        .counter_out(counter_out), .total_out(total_out), .alarm(alarm), .ovf(ovf), .unf(unf)
    );

    device_monitor_multi #(.WIDTH(8), .CHANNELS(4), .SATURATE(0), .THRESH(200)) dut_wrap (
        .clk(clk), .rst(rst), .change(change2), .on_off(on_off2), .clear(clear2),
        .counter_out(counter_out2), .total_out(total_out2), .alarm(alarm2), .ovf(ovf2), .unf(unf2)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held for 4 cycles
        tick(4);
        check("rst_cnt",   counter_out, 32'h0);
        check("rst_total", total_out, 10'd0);
        check("rst_flags", {alarm, ovf, unf}, 12'h0);
        rst = 1'b1;

        // ch0 counts up 10 cycles
        change = 4'b0001; on_off = 4'b0001;
        tick(10);
        check("up10_cnt",   counter_out, 32'h0000_000A);
        check("up10_total_lag", total_out, 10'd9);
        change = '0;
        tick();
        check("up10_total", total_out, 10'd10);

        // underflow on ch0, sticky until clear
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_cnt", counter_out, 32'h0);
        change = 4'b0001; on_off = 4'b0000;
        tick(3);
        check("unf_cnt", counter_out, 32'h0);
        check("unf_flag", unf, 4'b0001);
        change = '0;
        tick(2);
        check("unf_sticky", unf, 4'b0001);
        clear = 1'b1; tick(); clear = 1'b0;
        check("unf_clear", unf, 4'b0000);

        // independent channels: up, up, hold, down-at-zero
        change = 4'b1011; on_off = 4'b0011;
        tick(5);
        check("mix_cnt", counter_out, 32'h0000_0505);
        check("mix_unf", unf, 4'b1000);
        check("mix_ovf", ovf, 4'b0000);
        change = '0;
        tick();
        check("mix_total", total_out, 10'd10);
        clear = 1'b1; tick(); clear = 1'b0;

        // all channels up: alarm edge at 200, saturate at 255
        change = 4'hF; on_off = 4'hF;
        tick(199);
        check("a199_cnt", counter_out, 32'hC7C7_C7C7);
        check("a199_alarm", alarm, 4'h0);
        tick();
        check("a200_cnt", counter_out, 32'hC8C8_C8C8);
        check("a200_alarm", alarm, 4'hF);
        tick(60);
        check("sat_cnt", counter_out, 32'hFFFF_FFFF);
        check("sat_ovf", ovf, 4'hF);
        check("sat_alarm", alarm, 4'hF);
        check("sat_total", total_out, 10'd1020);
        check("sat_unf", unf, 4'h0);

        // clear wins over simultaneous counting
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_pri_cnt", counter_out, 32'h0);
        check("clr_pri_total", total_out, 10'd0);
        check("clr_pri_flags", {alarm, ovf, unf}, 12'h0);

        // async reset mid-count
        tick(3);
        check("pre_rst_cnt", counter_out, 32'h0303_0303);
        change = '0;
        tick();
        check("pre_rst_total", total_out, 10'd12);
        #3 rst = 1'b0;
        #1;
        check("async_rst_cnt", counter_out, 32'h0);
        check("async_rst_total", total_out, 10'd0);
        change = 4'hF; on_off = 4'hF; clear = 1'b1;
        tick();
        check("rst_hold_cnt", counter_out, 32'h0);
        clear = 1'b0;
        #3 rst = 1'b1;
        tick();
        check("resume_cnt", counter_out, 32'h0101_0101);
        change = '0;

        // wrap-around instance on ch2
        change2 = 4'b0100; on_off2 = 4'b0000;
        tick();
        check("wrap_dn_cnt", counter_out2, 32'h00FF_0000);
        check("wrap_dn_unf", unf2, 4'b0100);
        check("wrap_dn_alarm", alarm2, 4'b0100);
        on_off2 = 4'b0100;
        tick();
        check("wrap_up_cnt", counter_out2, 32'h0);
        check("wrap_up_ovf", ovf2, 4'b0100);
        change2 = '0;
        tick();
        check("wrap_total", total_out2, 10'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/device_monitor_multi.md
DEVICE_MONITOR_MULTI -- requirements
Module: device_monitor_multi

Interface
REQ-001 Parameter WIDTH, default 8: width of each per-channel device counter.
REQ-002 Parameter CHANNELS, default 4: number of independent monitored channels (range 1..16).
REQ-003 Parameter SATURATE, default 1: 1 selects saturating counters; 0 selects wrap-around counters.
REQ-004 Parameter THRESH, default 200: alarm threshold, a WIDTH-bit value.
REQ-005 Ports: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-006 Ports: rst  input  1  asynchronous reset, active-low.
REQ-007 Ports: change  input  CHANNELS  per-channel count enable.
REQ-008 Ports: on_off  input  CHANNELS  per-channel direction: 1 = increment (device on), 0 = decrement (device off).
REQ-009 Ports: clear  input  1  synchronous clear of all counters and sticky flags.
REQ-010 Ports: counter_out  output  CHANNELS*WIDTH  per-channel counts; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 Ports: total_out  output  WIDTH+clog2(CHANNELS)  registered sum of all channel counts.
REQ-012 Ports: alarm  output  CHANNELS  per-channel alarm, 1 while count >= THRESH.
REQ-013 Ports: ovf  output  CHANNELS  sticky overflow flags.
REQ-014 Ports: unf  output  CHANNELS  sticky underflow flags.

Function
REQ-015 On each rising clk edge with clear=0: channel i SHALL increment when change[i]=1 and on_off[i]=1, decrement when change[i]=1 and on_off[i]=0, and hold when change[i]=0.
REQ-016 Channels SHALL update independently and in the same cycle; no channel's input affects another channel's count.
REQ-017 SATURATE=1: an increment at 2^WIDTH-1 SHALL hold at 2^WIDTH-1 and set ovf[i]; a decrement at 0 SHALL hold at 0 and set unf[i].
REQ-018 SATURATE=0: an increment at 2^WIDTH-1 SHALL wrap to 0 and set ovf[i]; a decrement at 0 SHALL wrap to 2^WIDTH-1 and set unf[i].
REQ-019 ovf[i] and unf[i] SHALL remain 1 once set, until clear=1 or reset.
REQ-020 clear=1 SHALL, on the next rising edge, zero all counters, ovf, unf and total_out, overriding any change/on_off activity in that cycle.
REQ-021 alarm[i] SHALL be decoded combinationally from the registered count of channel i (count >= THRESH); it changes in the same cycle as the count, with no added latency.
REQ-022 total_out SHALL equal the sum of the counter values registered in the previous cycle, giving one cycle of latency behind counter_out; it SHALL never overflow, given its width.
REQ-023 Arithmetic SHALL be unsigned; with CHANNELS=1, total_out SHALL be WIDTH bits wide and equal the lone count delayed by one cycle.

Reset
REQ-024 When rst=0, all counters, total_out, ovf and unf SHALL go to 0 immediately, independent of clk; alarm SHALL then read 0 unless THRESH=0.
REQ-025 Reset asserted mid-count SHALL discard all state; after rst returns to 1, the first counting edge SHALL start from 0.
REQ-026 While rst=0, change, on_off and clear SHALL have no effect.

Verification (WIDTH=8, CHANNELS=4, SATURATE=1, THRESH=200 unless stated)
REQ-027 Reset 4 cycles, then change=4'b0001 and on_off=4'b0001 for 10 cycles -> ch0=10, ch1..3=0; total_out=10 one cycle after ch0 reaches 10.
REQ-028 ch0 at 0, then change[0]=1 and on_off[0]=0 for 3 cycles -> ch0 holds 0 and unf[0]=1; unf[0] stays 1 after change drops, until clear=1.
REQ-029 All channels incrementing for 260 cycles -> each channel=255, ovf=4'hF, alarm=4'hF from the cycle the counts reach 200, total_out=1020.
REQ-030 SATURATE=0, ch2 at 255, then one increment -> ch2=0 and ovf[2]=1; ch2 at 0, then one decrement -> ch2=255 and unf[2]=1.
REQ-031 clear=1 in the same cycle as change=4'hF and on_off=4'hF -> all counters, flags and total_out are 0 after that edge.
REQ-032 Counters at nonzero values, rst pulsed low between clock edges -> all outputs 0 before the next edge; counting resumes from 0 after release.
